// File: rtl/ttl_and_gate_scheduler_if.sv
// Requester/gate-side bundle of the shared AND-gate scheduler.
interface ttl_and_gate_scheduler_if #(
    parameter int BLOCKS   = 5,
    parameter int WIDTH_IN = 3
) ();
    logic [BLOCKS-1:0]          Req;
    logic [BLOCKS*WIDTH_IN-1:0] A_2D;
    logic                       Gate_Y;
    logic [WIDTH_IN-1:0]        Gate_A;
    logic [BLOCKS-1:0]          Grant;
    logic [BLOCKS-1:0]          Y;
    logic [BLOCKS-1:0]          Done;

    modport master (
        output Req, A_2D, Gate_Y,
        input  Gate_A, Grant, Y, Done
    );

    modport slave (
        input  Req, A_2D, Gate_Y,
        output Gate_A, Grant, Y, Done
    );
endinterface

// File: rtl/ttl_and_gate_scheduler.sv
// Round-robin time-sharing of one external AND gate among BLOCKS requesters.
// Latency: grant at edge E, Y/Done at edge E+SETTLE_CYCLES; next grant at E+SETTLE_CYCLES+1.
// Backpressure: requests are level-held; losers simply wait, Req drops during SETTLE are ignored.
module ttl_and_gate_scheduler #(
    parameter int BLOCKS        = 5,
    parameter int WIDTH_IN      = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int DELAY_RISE    = 0,
    parameter int DELAY_FALL    = 0
) (
    input  logic                     Clk,
    input  logic                     Clear_bar,
    ttl_and_gate_scheduler_if.slave  bus
);
    localparam int PTR_W = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t              state, state_nxt;
    logic [PTR_W-1:0]    ptr, owner, win;
    logic                win_vld;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH_IN-1:0] win_opnd;
    logic [WIDTH_IN-1:0] gate_a_r;
    logic [BLOCKS-1:0]   grant_r, y_r, done_r;

    // Output delays only matter to behavioural models; synthesized outputs are plain flops.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_delays_not_modelled
    end

    function automatic int wrap_idx(int p, int k);
        int s;
        s = p + k;
        return (s >= BLOCKS) ? s - BLOCKS : s;
    endfunction

    // First requester at or after ptr, in circular order.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        for (int k = 0; k < BLOCKS; k++) begin
            if (!win_vld && bus.Req[wrap_idx(int'(ptr), k)]) begin
                win     = PTR_W'(wrap_idx(int'(ptr), k));
                win_vld = 1'b1;
            end
        end
        win_opnd = bus.A_2D[win*WIDTH_IN +: WIDTH_IN];
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)          state_nxt = SETTLE;
            SETTLE:  if (cnt == '0)        state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            gate_a_r <= '0;
            grant_r  <= '0;
            y_r      <= '0;
            done_r   <= '0;
        end else begin
            done_r <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner    <= win;
                        grant_r  <= BLOCKS'(1) << win;
                        gate_a_r <= win_opnd;
                        cnt      <= CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        grant_r  <= '0;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        // Gate_Y is captured verbatim, including x/z from the package.
                        y_r[owner]    <= bus.Gate_Y;
                        done_r[owner] <= 1'b1;
                        grant_r       <= '0;
                        ptr           <= (owner == PTR_W'(BLOCKS - 1)) ? '0 : owner + PTR_W'(1);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: grant_r <= '0;
            endcase
        end
    end

    assign bus.Gate_A = gate_a_r;
    assign bus.Grant  = grant_r;
    assign bus.Y      = y_r;
    assign bus.Done   = done_r;
endmodule

// File: tb/tb_ttl_and_gate_scheduler.sv
// Directed bench for ttl_and_gate_scheduler with a behavioural 3-input AND gate as the shared package.
module tb_ttl_and_gate_scheduler;
    logic Clk;
    logic Clear_bar;
    int   total;
    int   bad;

    ttl_and_gate_scheduler_if #(.BLOCKS(5), .WIDTH_IN(3)) bus ();

    ttl_and_gate_scheduler #(
        .BLOCKS(5), .WIDTH_IN(3), .SETTLE_CYCLES(2), .DELAY_RISE(0), .DELAY_FALL(0)
    ) dut (
        .Clk(Clk),
        .Clear_bar(Clear_bar),
        .bus(bus.slave)
    );

    // Shared gate: output settles 5 time units after its inputs change.
    assign #5 bus.Gate_Y = &bus.Gate_A;

    initial begin
        Clk = 1'b0;
        forever #10 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Called just before the grant edge; applies req_mid/a_mid during SETTLE.
    task automatic run_op(input string tag, input logic [4:0] g, input logic [2:0] ga,
                          input logic [4:0] ynew, input logic [4:0] req_mid,
                          input logic [14:0] a_mid);
        tick();
        chk({tag, ".grant"},  32'(bus.Grant),  32'(g));
        chk({tag, ".gate_a"}, 32'(bus.Gate_A), 32'(ga));
        chk({tag, ".done0"},  32'(bus.Done),   32'(5'b00000));
        bus.Req  = req_mid;
        bus.A_2D = a_mid;
        tick();
        chk({tag, ".grant_hold"}, 32'(bus.Grant), 32'(g));
        chk({tag, ".done1"},      32'(bus.Done),  32'(5'b00000));
        tick();
        chk({tag, ".done"},       32'(bus.Done),  32'(g));
        chk({tag, ".grant_off"},  32'(bus.Grant), 32'(5'b00000));
        chk({tag, ".y"},          32'(bus.Y),     32'(ynew));
    endtask

    task automatic reset_pulse();
        Clear_bar = 1'b0;
        tick();
        Clear_bar = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        Clear_bar = 1'b1;
        bus.Req   = 5'b11111;
        bus.A_2D  = '1;
        #1 Clear_bar = 1'b0;

        // Reset dominates pending requests
        tick();
        chk("rst.grant",  32'(bus.Grant),  32'(5'b00000));
        chk("rst.y",      32'(bus.Y),      32'(5'b00000));
        chk("rst.done",   32'(bus.Done),   32'(5'b00000));
        chk("rst.gate_a", 32'(bus.Gate_A), 32'(3'b000));
        tick();
        chk("rst.grant2", 32'(bus.Grant),  32'(5'b00000));

        // Single request
        Clear_bar = 1'b1;
        bus.Req   = 5'b00001;
        bus.A_2D  = 15'b000_000_000_000_111;
        run_op("t2", 5'b00001, 3'b111, 5'b00001, 5'b00000, 15'b000_000_000_000_111);
        tick();
        chk("t2.idle_done",  32'(bus.Done),  32'(5'b00000));
        chk("t2.idle_grant", 32'(bus.Grant), 32'(5'b00000));
        chk("t2.y_hold",     32'(bus.Y),     32'(5'b00001));

        // All requesting: full rotation from ptr=0
        reset_pulse();
        bus.Req  = 5'b11111;
        bus.A_2D = 15'b111_101_010_111_000;
        run_op("t3.r0", 5'b00001, 3'b000, 5'b00000, 5'b11111, 15'b111_101_010_111_000);
        run_op("t3.r1", 5'b00010, 3'b111, 5'b00010, 5'b11111, 15'b111_101_010_111_000);
        run_op("t3.r2", 5'b00100, 3'b010, 5'b00010, 5'b11111, 15'b111_101_010_111_000);
        run_op("t3.r3", 5'b01000, 3'b101, 5'b00010, 5'b11111, 15'b111_101_010_111_000);
        run_op("t3.r4", 5'b10000, 3'b111, 5'b10010, 5'b00000, 15'b111_101_010_111_000);
        tick();
        chk("t3.end_grant", 32'(bus.Grant), 32'(5'b00000));
        chk("t3.end_done",  32'(bus.Done),  32'(5'b00000));
        chk("t3.end_y",     32'(bus.Y),     32'(5'b10010));

        // Wrap from ptr=4 to requester 0, then on to requester 3
        reset_pulse();
        bus.Req  = 5'b01000;
        bus.A_2D = 15'b000_111_000_000_111;
        run_op("t4.r3", 5'b01000, 3'b111, 5'b01000, 5'b01001, 15'b000_111_000_000_111);
        run_op("t4.r0", 5'b00001, 3'b111, 5'b01001, 5'b01001, 15'b000_101_000_000_111);
        run_op("t4.r3b", 5'b01000, 3'b101, 5'b00001, 5'b00000, 15'b000_101_000_000_111);

        // Operand and request changes during SETTLE are ignored
        bus.Req  = 5'b00001;
        bus.A_2D = 15'b000_000_000_000_011;
        run_op("t5.a", 5'b00001, 3'b011, 5'b00000, 5'b00001, 15'b000_000_000_000_111);
        run_op("t5.b", 5'b00001, 3'b111, 5'b00001, 5'b00000, 15'b000_000_000_000_000);

        // Reset mid-SETTLE aborts the operation
        bus.Req  = 5'b00100;
        bus.A_2D = 15'b000_000_111_000_000;
        tick();
        chk("t6.grant", 32'(bus.Grant), 32'(5'b00100));
        Clear_bar = 1'b0;
        #1;
        chk("t6.abort_grant",  32'(bus.Grant),  32'(5'b00000));
        chk("t6.abort_gate_a", 32'(bus.Gate_A), 32'(3'b000));
        chk("t6.abort_y",      32'(bus.Y),      32'(5'b00000));
        chk("t6.abort_done",   32'(bus.Done),   32'(5'b00000));
        tick();
        chk("t6.no_done", 32'(bus.Done), 32'(5'b00000));
        Clear_bar = 1'b1;
        bus.Req   = 5'b11111;
        bus.A_2D  = 15'b000_000_000_000_111;
        run_op("t6.after", 5'b00001, 3'b111, 5'b00001, 5'b00000, 15'b000_000_000_000_111);
        tick();
        chk("t6.final_done", 32'(bus.Done), 32'(5'b00000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
